// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU and the memory.
// The LSU is the master; the memory answers with ack and read data.
interface mem_stage_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one bus access per EX/MEM
// instruction, aligns stores, extends loads, reports errors.
module mem_stage_lsu #(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] addr_in,
    input  logic [DATAWIDTH-1:0] wdata_in,
    input  logic                 MEMRw_in,
    input  logic [1:0]           WBsel_in,
    input  logic [2:0]           Rsel_in,
    input  logic [1:0]           Wsel_in,
    output logic                 stall,
    output logic [DATAWIDTH-1:0] rdata_out,
    output logic                 rdata_valid,
    output logic                 err,
    output logic [1:0]           err_code,
    mem_stage_lsu_if.master      bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        req_q, we_q, load_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  rsel_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, err_q;
    logic [1:0]  code_q;

    logic        is_store, is_load, is_acc;
    logic        illegal, misalign, legal;
    logic [1:0]  size, off;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, shifted, ext_d;

    assign off      = addr_in[1:0];
    assign is_store = MEMRw_in;
    assign is_load  = (WBsel_in == 2'b01) & ~MEMRw_in;
    assign is_acc   = is_store | is_load;
    assign size     = is_store ? Wsel_in : Rsel_in[1:0];
    assign misalign = ((size == 2'b01) & addr_in[0])
                    | ((size == 2'b10) & (|addr_in[1:0]));
    assign legal    = is_acc & ~illegal & ~misalign;

    // Decode illegal size/type codes for the access kind present
    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = (Wsel_in == 2'b11);
        end else if (is_load) begin
            illegal = !(Rsel_in inside {3'b000, 3'b001, 3'b010,
                                        3'b100, 3'b101});
        end
    end

    // Replicate store data across lanes and place the byte enables
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        unique case (Wsel_in)
            2'b00: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << off;
                wdata_d = {2{wdata_in[15:0]}};
            end
            2'b10: begin
                be_d    = 4'b1111;
                wdata_d = wdata_in;
            end
            default: begin
                be_d    = 4'b0000;
                wdata_d = 32'h0;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and extend it
    always_comb begin
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        ext_d   = bus.mem_rdata;
        unique case (rsel_q)
            3'b000:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_d = {24'h0, shifted[7:0]};
            3'b001:  ext_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_d = {16'h0, shifted[15:0]};
            default: ext_d = bus.mem_rdata;
        endcase
    end

    // The pipeline holds while a legal access starts and while the bus is busy
    assign stall = (state_q == BUSY) | ((state_q == IDLE) & legal);

    // Request/response FSM with registered bus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            off_q    <= 2'b00;
            rsel_q   <= 3'b000;
            load_q   <= 1'b0;
            cnt_q    <= 8'h0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (legal) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {addr_in[31:2], 2'b00};
                        wdata_q <= is_store ? wdata_d : 32'h0;
                        be_q    <= is_store ? be_d : 4'b0000;
                        off_q   <= off;
                        rsel_q  <= Rsel_in;
                        load_q  <= ~is_store;
                        cnt_q   <= 8'h0;
                    end else if (is_acc) begin
                        err_q  <= 1'b1;
                        code_q <= illegal ? 2'b10 : 2'b01;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack || cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q  <= DONE;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= 32'h0;
                        wdata_q  <= 32'h0;
                        be_q     <= 4'b0000;
                        rvalid_q <= load_q;
                        if (bus.mem_ack) begin
                            if (load_q) rdata_q <= ext_d;
                        end else begin
                            if (load_q) rdata_q <= 32'h0;
                            err_q  <= 1'b1;
                            code_q <= 2'b11;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign rdata_out     = rdata_q;
    assign rdata_valid   = rvalid_q;
    assign err           = err_q;
    assign err_code      = code_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed plan items then random accesses,
// each checked against an arithmetic model of the access rules.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, wdata_in;
    logic        MEMRw_in;
    logic [1:0]  WBsel_in, Wsel_in;
    logic [2:0]  Rsel_in;
    logic        stall, rdata_valid, err;
    logic [31:0] rdata_out;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rd;
    logic [1:0]  m_code;

    mem_stage_lsu_if bif ();

    mem_stage_lsu #(.DATAWIDTH(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .MEMRw_in   (MEMRw_in),
        .WBsel_in   (WBsel_in),
        .Rsel_in    (Rsel_in),
        .Wsel_in    (Wsel_in),
        .stall      (stall),
        .rdata_out  (rdata_out),
        .rdata_valid(rdata_valid),
        .err        (err),
        .err_code   (err_code),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noop();
        addr_in  = $urandom;
        wdata_in = $urandom;
        MEMRw_in = 1'b0;
        WBsel_in = 2'b00;
        Rsel_in  = 3'($urandom_range(0, 7));
        Wsel_in  = 2'($urandom_range(0, 3));
    endtask

    // One EX/MEM instruction; dly = BUSY cycle of ack, >= TO means none
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic rw, input logic [1:0] wb,
                          input logic [2:0] rs, input logic [1:0] ws,
                          input logic [31:0] rd, input int dly);
        bit st, ld, acc, ill, mis, ok, tmo;
        int sz, o, n, req_cnt, stall_cnt;
        logic [31:0] e_be, e_wd, sh, v;
        st  = rw;
        ld  = (wb == 2'b01) && !rw;
        acc = st || ld;
        o   = int'(a[1:0]);
        if (st) begin
            ill = (ws == 2'b11);
            sz  = 1 << ws;
        end else begin
            ill = !(rs inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            sz  = 1 << rs[1:0];
        end
        mis = !ill && (sz <= 4) && ((o % sz) != 0);
        ok  = acc && !ill && !mis;
        tmo = (dly >= TO);
        e_be = 0;
        e_wd = 0;
        if (st) begin
            if (ws == 0) begin
                e_be = 32'(1 << o);
                e_wd = 32'(wd[7:0]) * 32'h01010101;
            end else if (ws == 1) begin
                e_be = 32'(3 << o);
                e_wd = 32'(wd[15:0]) * 32'h00010001;
            end else begin
                e_be = 15;
                e_wd = wd;
            end
        end
        sh = rd >> (8 * o);
        v  = rd;
        if (rs[1:0] == 0) begin
            v = sh & 32'hFF;
            if (rs[2] == 0 && v >= 128) v = v - 256;
        end else if (rs[1:0] == 1) begin
            v = sh & 32'hFFFF;
            if (rs[2] == 0 && v >= 32768) v = v - 65536;
        end
        addr_in = a; wdata_in = wd; MEMRw_in = rw;
        WBsel_in = wb; Rsel_in = rs; Wsel_in = ws;
        #1;
        chk("stall_detect", stall, ok);
        if (!acc) begin
            step();
            chk("idle_req", bif.mem_req, 0);
            chk("idle_err", err, 0);
            chk("idle_rdata", rdata_out, m_rd);
            return;
        end
        if (!ok) begin
            step();
            noop();
            #1;
            m_code = ill ? 2'b10 : 2'b01;
            chk("err_pulse", err, 1);
            chk("err_code", err_code, m_code);
            chk("err_req", bif.mem_req, 0);
            chk("err_stall", stall, 0);
            step();
            chk("err_once", err, 0);
            chk("err_hold", err_code, m_code);
            return;
        end
        stall_cnt = 1;
        req_cnt   = 0;
        for (int k = 0; k < TO; k++) begin
            step();
            if (k == dly) begin
                bif.mem_ack   = 1'b1;
                bif.mem_rdata = rd;
            end else begin
                bif.mem_ack   = 1'b0;
                bif.mem_rdata = $urandom;
            end
            #1;
            if (stall) stall_cnt++;
            if (bif.mem_req) req_cnt++;
            chk("busy_addr", bif.mem_addr, {a[31:2], 2'b00});
            chk("busy_we", bif.mem_we, st);
            chk("busy_be", bif.mem_be, e_be);
            if (st) chk("busy_wdata", bif.mem_wdata, e_wd);
            if (k == dly) break;
        end
        step();
        bif.mem_ack   = 1'b0;
        bif.mem_rdata = $urandom;
        #1;
        n = tmo ? TO : dly + 1;
        if (ld) m_rd = tmo ? 32'h0 : v;
        if (tmo) m_code = 2'b11;
        chk("req_cycles", req_cnt, n);
        chk("stall_cycles", stall_cnt, n + 1);
        chk("done_stall", stall, 0);
        chk("done_req", bif.mem_req, 0);
        chk("done_valid", rdata_valid, ld);
        chk("done_rdata", rdata_out, m_rd);
        chk("done_err", err, tmo);
        chk("done_code", err_code, m_code);
        step();
        noop();
        #1;
        chk("after_req", bif.mem_req, 0);
        chk("after_valid", rdata_valid, 0);
        chk("after_err", err, 0);
        chk("after_be", bif.mem_be, 0);
        chk("after_rdata", rdata_out, m_rd);
    endtask

    initial begin
        rst = 1'b1;
        bif.mem_ack   = 1'b0;
        bif.mem_rdata = 32'h0;
        noop();
        m_rd   = 32'h0;
        m_code = 2'b00;
        #12;
        chk("rst_req", bif.mem_req, 0);
        chk("rst_we", bif.mem_we, 0);
        chk("rst_addr", bif.mem_addr, 0);
        chk("rst_wdata", bif.mem_wdata, 0);
        chk("rst_be", bif.mem_be, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_stall", stall, 0);
        step();
        rst = 1'b0;
        step();

        access(32'h100, 0, 0, 2'b01, 3'b010, 0, 32'hDEADBEEF, 0);
        chk("lw_val", rdata_out, 32'hDEADBEEF);
        access(32'h103, 0, 0, 2'b01, 3'b000, 0, 32'h80FF1234, 1);
        chk("lb_val", rdata_out, 32'hFFFFFF80);
        access(32'h103, 0, 0, 2'b01, 3'b100, 0, 32'h80FF1234, 2);
        chk("lbu_val", rdata_out, 32'h00000080);
        access(32'h102, 32'h0000ABCD, 1, 2'b01, 0, 2'b01, 0, 0);
        access(32'h101, 0, 0, 2'b01, 3'b010, 0, 0, 0);
        chk("misalign_code", err_code, 2'b01);
        access(32'h100, 0, 0, 2'b01, 3'b011, 0, 0, 0);
        chk("illegal_code", err_code, 2'b10);
        access(32'h204, 0, 0, 2'b01, 3'b001, 0, 32'h12345678, TO + 3);
        chk("tmo_code", err_code, 2'b11);
        chk("tmo_rdata", rdata_out, 0);

        addr_in = 32'h200; MEMRw_in = 1'b0;
        WBsel_in = 2'b01; Rsel_in = 3'b010;
        step();
        chk("rb_busy1", bif.mem_req, 1);
        step();
        chk("rb_busy2", bif.mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rb_req_async", bif.mem_req, 0);
        noop();
        bif.mem_ack   = 1'b1;
        bif.mem_rdata = 32'hCAFEF00D;
        #1;
        chk("rb_stall", stall, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rb_valid0", rdata_valid, 0);
        chk("rb_req0", bif.mem_req, 0);
        step();
        m_rd   = 32'h0;
        m_code = 2'b00;
        chk("rb_valid1", rdata_valid, 0);
        chk("rb_rdata", rdata_out, m_rd);
        chk("rb_req1", bif.mem_req, 0);
        chk("rb_stall1", stall, 0);
        bif.mem_ack = 1'b0;

        access(32'h300, 0, 0, 2'b01, 3'b010, 0, 32'h0BADF00D, 0);
        for (int k = 0; k < 3; k++) begin
            bif.mem_ack   = 1'b1;
            bif.mem_rdata = $urandom;
            step();
            chk("stray_req", bif.mem_req, 0);
            chk("stray_valid", rdata_valid, 0);
            chk("stray_rdata", rdata_out, m_rd);
            chk("stray_err", err, 0);
            chk("stray_code", err_code, m_code);
            chk("stray_stall", stall, 0);
        end
        bif.mem_ack = 1'b0;

        for (int i = 0; i < 80; i++) begin
            access($urandom, $urandom,
                   1'($urandom_range(0, 2) == 0),
                   2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 1),
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, int'($urandom_range(0, TO + 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit driven by the EX/MEM pipeline register outputs. It turns the EX/MEM fields into a request on the data-memory bus: ALU address, store data, read/write flag, load select and store select. It aligns store data and byte enables, sign- or zero-extends returned load data, and holds the pipeline (through the `en` inputs of the pipeline registers) until the bus completes. It also flags misaligned accesses, illegal access codes and bus timeouts.

## Interface
- `DATAWIDTH`, 32, datapath width; only 32 is supported.
- `TIMEOUT`, 16, maximum cycles to wait for `mem_ack` per request; legal range 1..255.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `addr_in` input 32: byte address, the ALU result from EX/MEM.
- `wdata_in` input 32: store data from rs2, right-justified.
- `MEMRw_in` input 1: 1 = store, 0 = no store.
- `WBsel_in` input 2: writeback select. 00 = ALU, 01 = memory (marks a load), 10 = pc+4, 11 = reserved.
- `Rsel_in` input 3: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- `Wsel_in` input 2: store size. 00 SB, 01 SH, 10 SW; 11 is illegal.
- `stall` output 1: 1 = hold the pipeline. Drives the inverted `en` of PC/IF-ID/ID-EX/EX-MEM.
- `rdata_out` output 32: extended load data, written into MEM/WB.
- `rdata_valid` output 1: one-cycle pulse when `rdata_out` is updated.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: 01 misaligned, 10 illegal select code, 11 bus timeout; holds its last value.
- `mem_req` output 1: bus request, registered.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word-aligned address, `{addr_in[31:2],2'b00}`.
- `mem_wdata` output 32: lane-aligned store data.
- `mem_be` output 4: byte enables; 4'b0000 on reads.
- `mem_ack` input 1: bus completion, sampled only while `mem_req` is 1.
- `mem_rdata` input 32: read word, valid in the cycle `mem_ack` is 1.

## Operation
- Access detect: `store = MEMRw_in`; `load = (WBsel_in==2'b01) & ~MEMRw_in`. If both fields are set, the store wins.
- Alignment check:
  - Halfword accesses require `addr_in[0]==0`.
  - Word accesses require `addr_in[1:0]==0`.
  - Byte accesses are always aligned.
- Store lane steering, using `o = addr_in[1:0]`:
  - SB: `mem_wdata = {4{wdata_in[7:0]}}`, `mem_be = 4'b0001<<o`.
  - SH: `mem_wdata = {2{wdata_in[15:0]}}`, `mem_be = 4'b0011<<o`.
  - SW: `mem_wdata = wdata_in`, `mem_be = 4'b1111`.
- Load extraction, using the offset latched at request time:
  - Byte loads select `mem_rdata[8*o +: 8]`; LB sign-extends, LBU zero-extends.
  - Halfword loads select `mem_rdata[8*o +: 16]`; LH sign-extends, LHU zero-extends.
  - LW passes the word through unchanged.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - Legal aligned access: `stall`=1 combinationally; latch address/offset/type/data/byte enables; next state BUSY with `mem_req`=1 and the timeout counter cleared.
  - Misaligned or illegal access: no bus request, `stall`=0. Pulse `err` next cycle with code 01 or 10; remain IDLE.
  - Misaligned or illegal access that reaches IDLE again in consecutive cycles (pipeline frozen by another source) pulses `err` each time; upstream flushes.
  - No access: idle; every output except `rdata_out`/`err_code` stays 0.
- BUSY:
  - `stall`=1; bus outputs stay stable.
  - `mem_ack`=1: drop `mem_req`; on a load, register the extended data into `rdata_out`; next state DONE.
  - Counter reaches TIMEOUT−1 without ack: drop `mem_req`, set `rdata_out`=0, `err`=1 with code 11, next state DONE.
- DONE:
  - `stall`=0 so the pipeline advances this cycle.
  - `rdata_valid`=1 for loads only, including a timed-out load (data 0).
  - No new access is started; next state IDLE unconditionally, so the same EX/MEM instruction is never issued twice.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - `rdata_out` = 0, `rdata_valid` = 0, `err` = 0, `err_code` = 00, `stall` = 0.
- Reset mid-BUSY aborts the transfer: `mem_req` drops asynchronously and a late `mem_ack` is discarded.
- Minimum access: 3 cycles (IDLE detect, BUSY with same-cycle ack, DONE), so `stall` is high for 2 cycles.
- A load result is visible in `rdata_out` from the DONE cycle and is held until the next load completes.
- Timeout: `stall` is high for TIMEOUT+1 cycles in total.
- Back-to-back accesses: the second one is detected in the IDLE cycle after DONE, with no dead cycle beyond DONE.

## Test plan
- LW with `addr_in`=0x100 and `mem_rdata`=0xDEADBEEF, ack on the first BUSY cycle:
  - `mem_addr`=0x100 and `mem_be`=0000.
  - `stall` high for 2 cycles.
  - `rdata_out`=0xDEADBEEF with `rdata_valid` in DONE.
- LB/LBU at 0x103 with `mem_rdata`=0x80FF1234: LB gives `rdata_out`=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x102 with `wdata_in`=0x0000ABCD: `mem_wdata`=0xABCDABCD, `mem_be`=1100, `mem_we`=1, `rdata_valid` stays 0.
- Error codes:
  - LW at 0x101: no `mem_req`, `err`=1 with `err_code`=01 for one cycle, `stall` never high.
  - `Rsel_in`=011 load: `err_code`=10.
- TIMEOUT=4 with `mem_ack` held low:
  - `mem_req` high exactly 4 cycles.
  - Then `err_code`=11, `rdata_out`=0, `rdata_valid`=1, `stall` released.
- Reset and stray ack:
  - Assert `rst` in the 2nd BUSY cycle, then `mem_ack`=1: `mem_req`=0 immediately, state IDLE, no `rdata_valid`.
  - `mem_ack` pulsed while IDLE: no output change.
